// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_ADDR_W = 10;

    // IDLE: waiting for start, LOAD: collecting bytes,
    // WRITE: one-cycle RAM write, DONE: image complete (sticky).
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: collects four accepted bytes into a 32-bit word.
// Lanes 0..2 are stored; lane 3 is taken straight from the incoming byte so the
// complete word is available in the same cycle the fourth byte is accepted.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  byte_idx_q;
    logic [23:0] lanes;

    // Byte index advances on every accepted byte and wraps after the fourth.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            byte_idx_q <= 2'd0;
        end else if (accept_i) begin
            byte_idx_q <= byte_idx_q + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_q;

            // Capture the byte destined for this lane when its index comes up.
            always_ff @(posedge clk) begin
                if (reset || clear_i) begin
                    lane_q <= 8'h00;
                end else if (accept_i && (byte_idx_q == 2'(gi))) begin
                    lane_q <= byte_i;
                end
            end

            assign lanes[8*gi +: 8] = lane_q;
        end
    endgenerate

    assign word_o       = {byte_i, lanes};
    assign word_valid_o = accept_i && (byte_idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction RAM as little-endian words starting at
// word 0, holds the core while loading and keeps a running word checksum.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic [31:0]       checksum
);

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);

    loader_state_t   state_q, state_d;
    logic [ADDR_W:0] n_q, n_d;
    logic [ADDR_W:0] word_cnt_q, word_cnt_d;
    logic [31:0]     checksum_q, checksum_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;

    logic            pack_clear;
    logic            byte_accept;
    logic [31:0]     packed_word;
    logic            word_valid;
    logic [ADDR_W:0] n_clamped;

    // Oversized requests are clamped so the address never runs past the RAM.
    assign n_clamped   = (num_words > DEPTH_N) ? DEPTH_N : num_words;
    assign byte_accept = byte_valid && byte_ready;

    imem_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (pack_clear),
        .accept_i     (byte_accept),
        .byte_i       (byte_data),
        .word_o       (packed_word),
        .word_valid_o (word_valid)
    );

    // Next-state logic for the load sequence, word counter and checksum.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        checksum_d  = checksum_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pack_clear  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d        = n_clamped;
                    word_cnt_d = '0;
                    checksum_d = 32'h0;
                    pack_clear = 1'b1;
                    state_d    = (n_clamped == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    // Address uses the count before this word's increment.
                    mem_addr_d  = {{(30-ADDR_W){1'b0}}, word_cnt_q[ADDR_W-1:0], 2'b00};
                    mem_wdata_d = packed_word;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                checksum_d = checksum_q + mem_wdata_q;
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d == n_q) ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any load in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            word_cnt_q  <= '0;
            checksum_q  <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            checksum_q  <= checksum_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign byte_ready = (state_q == ST_LOAD);
    assign mem_we     = (state_q == ST_WRITE);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_WRITE);
    assign cpu_hold   = busy;
    assign done       = (state_q == ST_DONE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign checksum   = checksum_q;

endmodule
